// File: rtl/bram_dp_arbiter.sv
// bram_dp_arbiter
//
// Shares one dual-port block RAM among N_REQ requesters. Each cycle up to two
// requests are granted in round-robin order, one on RAM port A and one on
// RAM port B. Registered read data is steered back to the requester that
// issued each read, one cycle after its grant.
//
// Build option BRAM_ARB_INIT_CLEAR_EN: when defined, the RAM is zeroed two
// words per cycle after every reset before any request is accepted. When it
// is undefined, no clear logic exists and the arbiter runs straight out of
// reset with ready_o tied high.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_CLEAR | writing zero to addresses 2k (port A) and 2k+1 (port B); no grants
// S_RUN   | round-robin arbitration of req_i onto the two RAM ports

module bram_dp_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int N_ENTRIES  = 128,
    localparam int AW        = $clog2(N_ENTRIES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ-1:0]              we_i,
    input  logic [N_REQ*AW-1:0]           addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic [N_REQ-1:0]              rvalid_o,
    output logic [N_REQ*DATA_WIDTH-1:0]   rdata_o,
    output logic                          ready_o,

    output logic                          mem_en_o,
    output logic                          mem_a_we_o,
    output logic                          mem_b_we_o,
    output logic [AW-1:0]                 mem_a_addr_o,
    output logic [AW-1:0]                 mem_b_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_a_data_o,
    output logic [DATA_WIDTH-1:0]         mem_b_data_o,
    input  logic [DATA_WIDTH-1:0]         mem_a_data_i,
    input  logic [DATA_WIDTH-1:0]         mem_b_data_i
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int KW = (AW > 1) ? AW - 1 : 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          state_q;
    logic            clear_active;
    logic [AW-1:0]   clr_addr_a;
    logic [AW-1:0]   clr_addr_b;
    logic            ready_q;

    // Per-requester views of the packed request buses.
    logic [AW-1:0]         addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

    // Arbitration results.
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   w0;
    logic [PW-1:0]   w1;
    logic            found0;
    logic            found1;
    logic            conflict;
    logic            gnt0;
    logic            gnt1;

    // Outstanding read record per RAM port.
    logic            rd_a_vld_q;
    logic [PW-1:0]   rd_a_id_q;
    logic            rd_b_vld_q;
    logic [PW-1:0]   rd_b_id_q;

    // Circular successor of base by off positions, modulo N_REQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base,
                                               input int unsigned   off);
        int unsigned sum;
        sum = 32'(base) + off;
        return PW'(sum % N_REQ);
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*AW +: AW];
        assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef BRAM_ARB_INIT_CLEAR_EN
    localparam logic [KW-1:0] CLR_LAST = KW'(N_ENTRIES/2 - 1);

    state_t          state_d;
    logic [KW-1:0]   clr_k_q;
    logic [KW-1:0]   clr_k_d;

    // State, clear counter and ready flag; ready tracks entry into S_RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_CLEAR;
            clr_k_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_k_q <= clr_k_d;
            ready_q <= (state_d == S_RUN);
        end
    end

    // Next state: step the clear counter and leave S_CLEAR after the last pair.
    always_comb begin
        state_d = state_q;
        clr_k_d = clr_k_q;
        if (state_q == S_CLEAR) begin
            if (clr_k_q == CLR_LAST) begin
                state_d = S_RUN;
                clr_k_d = '0;
            end else begin
                clr_k_d = clr_k_q + 1'b1;
            end
        end
    end

    assign clear_active = (state_q == S_CLEAR);
    assign clr_addr_a   = AW'({clr_k_q, 1'b0});
    assign clr_addr_b   = AW'({clr_k_q, 1'b1});
`else
    assign state_q      = S_RUN;
    assign clear_active = 1'b0;
    assign clr_addr_a   = '0;
    assign clr_addr_b   = '0;
    assign ready_q      = 1'b1;
`endif

    assign ready_o = ready_q;

    // Circular scan from rr_ptr: first request wins port A, next wins port B.
    always_comb begin
        found0 = 1'b0;
        found1 = 1'b0;
        w0     = '0;
        w1     = '0;
        cand   = '0;
        for (int o = 0; o < N_REQ; o++) begin
            cand = wrap_idx(rr_ptr_q, o);
            if (req_i[cand]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    w0     = cand;
                end else if (!found1) begin
                    found1 = 1'b1;
                    w1     = cand;
                end
            end
        end
        // A write racing another access to the same word is serialised;
        // two reads of one word are harmless and both proceed.
        conflict = found1 && (addr_arr[w0] == addr_arr[w1]) &&
                   (we_i[w0] || we_i[w1]);
    end

    // Grants and RAM port drive; reset forces everything quiet at once.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        gnt_o        = '0;
        mem_en_o     = 1'b0;
        mem_a_we_o   = 1'b0;
        mem_b_we_o   = 1'b0;
        mem_a_addr_o = '0;
        mem_b_addr_o = '0;
        mem_a_data_o = '0;
        mem_b_data_o = '0;
        if (!rst_i) begin
            if (clear_active) begin
                mem_en_o     = 1'b1;
                mem_a_we_o   = 1'b1;
                mem_b_we_o   = 1'b1;
                mem_a_addr_o = clr_addr_a;
                mem_b_addr_o = clr_addr_b;
            end else begin
                gnt0 = found0;
                gnt1 = found1 && !conflict;
                if (gnt0) begin
                    gnt_o[w0]    = 1'b1;
                    mem_a_we_o   = we_i[w0];
                    mem_a_addr_o = addr_arr[w0];
                    mem_a_data_o = wdata_arr[w0];
                end
                if (gnt1) begin
                    gnt_o[w1]    = 1'b1;
                    mem_b_we_o   = we_i[w1];
                    mem_b_addr_o = addr_arr[w1];
                    mem_b_data_o = wdata_arr[w1];
                end
                mem_en_o = gnt0 || gnt1;
            end
        end
    end

    // Round-robin pointer moves just past the last requester granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (gnt0 || gnt1) begin
            rr_ptr_q <= wrap_idx(gnt1 ? w1 : w0, 1);
        end
    end

    // Remember which requester each port is reading for, one cycle deep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_a_vld_q <= 1'b0;
            rd_a_id_q  <= '0;
            rd_b_vld_q <= 1'b0;
            rd_b_id_q  <= '0;
        end else begin
            rd_a_vld_q <= gnt0 && !we_i[w0];
            rd_a_id_q  <= w0;
            rd_b_vld_q <= gnt1 && !we_i[w1];
            rd_b_id_q  <= w1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_ret
        localparam logic [PW-1:0] ID = PW'(g);

        logic                  hit_a;
        logic                  hit_b;
        logic [DATA_WIDTH-1:0] ret_data;
        logic [DATA_WIDTH-1:0] hold_q;

        // The two ports never return to the same requester in one cycle.
        assign hit_a    = rd_a_vld_q && (rd_a_id_q == ID);
        assign hit_b    = rd_b_vld_q && (rd_b_id_q == ID);
        assign ret_data = hit_a ? mem_a_data_i :
                          hit_b ? mem_b_data_i : hold_q;

        assign rvalid_o[g]                          = hit_a || hit_b;
        assign rdata_o[g*DATA_WIDTH +: DATA_WIDTH]  = ret_data;

        // Keep the last returned word visible between valid cycles.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                hold_q <= '0;
            end else if (hit_a || hit_b) begin
                hold_q <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// Directed bench for bram_dp_arbiter (N_REQ=4, 32-bit words, 128 entries)
// with a behavioural write-first dual-port RAM attached to the memory ports.

module tb_bram_dp_arbiter;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [3:0]    req;
    logic [3:0]    we;
    logic [6:0]    addr_a [4];
    logic [31:0]   wd     [4];
    logic [27:0]   addr;
    logic [127:0]  wdata;

    logic [3:0]    gnt;
    logic [3:0]    rvalid;
    logic [127:0]  rdata;
    logic          ready;
    logic          mem_en;
    logic          a_we;
    logic          b_we;
    logic [6:0]    a_addr;
    logic [6:0]    b_addr;
    logic [31:0]   a_data;
    logic [31:0]   b_data;
    logic [31:0]   a_q = '0;
    logic [31:0]   b_q = '0;
    logic [31:0]   rd [4];

    logic [31:0]   ram [128] = '{default: '0};

    int checks   = 0;
    int failures = 0;

    assign addr  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
    assign wdata = {wd[3], wd[2], wd[1], wd[0]};
    assign rd[0] = rdata[31:0];
    assign rd[1] = rdata[63:32];
    assign rd[2] = rdata[95:64];
    assign rd[3] = rdata[127:96];

    bram_dp_arbiter #(
        .N_REQ      (4),
        .DATA_WIDTH (32),
        .N_ENTRIES  (128)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .ready_o      (ready),
        .mem_en_o     (mem_en),
        .mem_a_we_o   (a_we),
        .mem_b_we_o   (b_we),
        .mem_a_addr_o (a_addr),
        .mem_b_addr_o (b_addr),
        .mem_a_data_o (a_data),
        .mem_b_data_o (b_data),
        .mem_a_data_i (a_q),
        .mem_b_data_i (b_q)
    );

    always #5 clk_i = ~clk_i;

    // Write-first dual-port RAM with registered read data.
    always @(posedge clk_i) begin
        if (mem_en) begin
            if (a_we) begin
                ram[a_addr] <= a_data;
                a_q         <= a_data;
            end else begin
                a_q <= ram[a_addr];
            end
            if (b_we) begin
                ram[b_addr] <= b_data;
                b_q         <= b_data;
            end else begin
                b_q <= ram[b_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [1:0] i, input logic w, input logic [6:0] a,
                           input logic [31:0] d);
        we[i]     = w;
        addr_a[i] = a;
        wd[i]     = d;
    endtask

`ifdef BRAM_ARB_INIT_CLEAR_EN
    // Walk the 64 clear cycles, checking each address pair and that requests are ignored.
    task automatic run_clear();
        req = 4'b1111;
        we  = 4'b0000;
        for (int k = 0; k < 64; k++) begin
            #1;
            chk("clr_en",    mem_en, 1'b1);
            chk("clr_awe",   a_we, 1'b1);
            chk("clr_bwe",   b_we, 1'b1);
            chk("clr_aaddr", a_addr, 7'(2*k));
            chk("clr_baddr", b_addr, 7'(2*k+1));
            chk("clr_data",  {a_data, b_data}, 64'h0);
            chk("clr_gnt",   gnt, 4'b0000);
            chk("clr_ready", ready, 1'b0);
            if (k == 63) req = 4'b0000;
            tick();
        end
        chk("clr_done_ready", ready, 1'b1);
        chk("clr_done_en",    mem_en, 1'b0);
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        req   = 4'b0000;
        we    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = '0;
            wd[i]     = '0;
        end

        tick();
        chk("rst_gnt",    gnt, 4'b0000);
        chk("rst_rvalid", rvalid, 4'b0000);
        chk("rst_rdata",  rdata, 128'h0);
        chk("rst_en",     mem_en, 1'b0);
        chk("rst_we",     {a_we, b_we}, 2'b00);
        chk("rst_addr",   {a_addr, b_addr}, 14'h0);
        chk("rst_data",   {a_data, b_data}, 64'h0);
`ifdef BRAM_ARB_INIT_CLEAR_EN
        chk("rst_ready",  ready, 1'b0);
`else
        chk("rst_ready",  ready, 1'b1);
`endif
        tick();
        rst_i = 1'b0;

`ifdef BRAM_ARB_INIT_CLEAR_EN
        // Reset in clear cycle 20, then the clear must start over from address 0.
        repeat (20) tick();
        chk("mid_clr_aaddr", a_addr, 7'd40);
        chk("mid_clr_baddr", b_addr, 7'd41);
        rst_i = 1'b1;
        #1;
        chk("mid_clr_rst_en",    mem_en, 1'b0);
        chk("mid_clr_rst_we",    {a_we, b_we}, 2'b00);
        chk("mid_clr_rst_addr",  {a_addr, b_addr}, 14'h0);
        chk("mid_clr_rst_ready", ready, 1'b0);
        tick();
        rst_i = 1'b0;
        run_clear();
`else
        #1;
        chk("norst_ready", ready, 1'b1);
        chk("norst_en",    mem_en, 1'b0);
`endif

        // Reads of 5 and 127 return zero.
        set_req(0, 1'b0, 7'd5, 32'h0);
        set_req(1, 1'b0, 7'd127, 32'h0);
        req = 4'b0011;
        #1;
        chk("zr_gnt",   gnt, 4'b0011);
        chk("zr_addr",  {a_addr, b_addr}, {7'd5, 7'd127});
        chk("zr_we",    {a_we, b_we}, 2'b00);
        tick();
        req = 4'b0000;
        chk("zr_rvalid", rvalid, 4'b0011);
        chk("zr_rdata",  {rd[1], rd[0]}, 64'h0);

        // Requester 3 writes 0x1234 to address 7; port B idles at zero.
        set_req(3, 1'b1, 7'd7, 32'h0000_1234);
        req = 4'b1000;
        #1;
        chk("w7_gnt",   gnt, 4'b1000);
        chk("w7_a",     {a_we, a_addr, a_data}, {1'b1, 7'd7, 32'h0000_1234});
        chk("w7_b_idle", {b_we, b_addr, b_data}, 40'h0);
        tick();
        req = 4'b0000;
        chk("w7_no_rvalid", rvalid, 4'b0000);

        // Preload addresses 20..23.
        set_req(0, 1'b1, 7'd20, 32'h1111_1111);
        set_req(1, 1'b1, 7'd21, 32'h2222_2222);
        req = 4'b0011;
        #1;
        chk("pre01_gnt", gnt, 4'b0011);
        chk("pre01_b",   {b_we, b_addr, b_data}, {1'b1, 7'd21, 32'h2222_2222});
        tick();
        set_req(2, 1'b1, 7'd22, 32'h3333_3333);
        set_req(3, 1'b1, 7'd23, 32'h4444_4444);
        req = 4'b1100;
        #1;
        chk("pre23_gnt", gnt, 4'b1100);
        chk("pre23_addr", {a_addr, b_addr}, {7'd22, 7'd23});
        tick();

        // Dual grant: four reads at rr_ptr=0 take two cycles.
        we  = 4'b0000;
        req = 4'b1111;
        #1;
        chk("dual1_gnt",  gnt, 4'b0011);
        chk("dual1_addr", {a_addr, b_addr}, {7'd20, 7'd21});
        tick();
        req = 4'b1100;
        chk("dual1_rvalid", rvalid, 4'b0011);
        chk("dual1_rdata",  {rd[1], rd[0]}, {32'h2222_2222, 32'h1111_1111});
        #1;
        chk("dual2_gnt",  gnt, 4'b1100);
        chk("dual2_addr", {a_addr, b_addr}, {7'd22, 7'd23});
        tick();
        req = 4'b0000;
        chk("dual2_rvalid", rvalid, 4'b1100);
        chk("dual2_rdata",  {rd[3], rd[2]}, {32'h4444_4444, 32'h3333_3333});
        chk("dual2_hold0",  rd[0], 32'h1111_1111);

        // Conflict: write and read of address 10 in the same cycle.
        set_req(0, 1'b1, 7'd10, 32'hA5A5_A5A5);
        set_req(1, 1'b0, 7'd10, 32'h0);
        req = 4'b0011;
        #1;
        chk("cf1_gnt", gnt, 4'b0001);
        chk("cf1_a",   {a_we, a_addr, a_data}, {1'b1, 7'd10, 32'hA5A5_A5A5});
        chk("cf1_b",   {b_we, b_addr}, 8'h0);
        tick();
        req = 4'b0010;
        chk("cf1_no_rvalid", rvalid, 4'b0000);
        #1;
        chk("cf2_gnt", gnt, 4'b0010);
        chk("cf2_a",   {a_we, a_addr}, {1'b0, 7'd10});
        tick();
        req = 4'b0000;
        chk("cf2_rvalid", rvalid, 4'b0010);
        chk("cf2_rdata",  rd[1], 32'hA5A5_A5A5);

        // Same-address reads of address 7 by requesters 2 and 3.
        set_req(2, 1'b0, 7'd7, 32'h0);
        set_req(3, 1'b0, 7'd7, 32'h0);
        req = 4'b1100;
        #1;
        chk("sa_gnt",  gnt, 4'b1100);
        chk("sa_addr", {a_addr, b_addr}, {7'd7, 7'd7});
        tick();
        req = 4'b0000;
        chk("sa_rvalid", rvalid, 4'b1100);
        chk("sa_rdata",  {rd[3], rd[2]}, {32'h0000_1234, 32'h0000_1234});

        // Fairness with continuous requesters and a late requester 3.
        set_req(0, 1'b0, 7'd20, 32'h0);
        set_req(1, 1'b0, 7'd21, 32'h0);
        set_req(2, 1'b0, 7'd22, 32'h0);
        set_req(3, 1'b0, 7'd23, 32'h0);
        req = 4'b1001;
        #1;
        chk("f1_gnt", gnt, 4'b1001);
        tick();
        req = 4'b0111;
        chk("f1_rvalid", rvalid, 4'b1001);
        chk("f1_rdata",  {rd[3], rd[0]}, {32'h4444_4444, 32'h1111_1111});
        #1;
        chk("f2_gnt", gnt, 4'b0011);
        tick();
        chk("f2_rvalid", rvalid, 4'b0011);
        chk("f2_rdata",  rd[1], 32'h2222_2222);
        #1;
        chk("f3_gnt", gnt, 4'b0101);
        tick();
        req = 4'b1111;
        chk("f3_rvalid", rvalid, 4'b0101);
        chk("f3_rdata",  rd[2], 32'h3333_3333);
        #1;
        chk("f4_gnt", gnt, 4'b0110);
        tick();
        chk("f4_rvalid", rvalid, 4'b0110);
        #1;
        chk("f5_gnt", gnt, 4'b1001);
        chk("f5_addr", {a_addr, b_addr}, {7'd23, 7'd20});
        tick();
        req = 4'b0011;
        chk("f5_rvalid", rvalid, 4'b1001);

        // Reset with two reads in flight.
        #1;
        chk("fl_gnt",  gnt, 4'b0011);
        chk("fl_addr", {a_addr, b_addr}, {7'd21, 7'd20});
        tick();
        rst_i = 1'b1;
        #1;
        chk("fl_rst_rvalid", rvalid, 4'b0000);
        chk("fl_rst_gnt",    gnt, 4'b0000);
        chk("fl_rst_en",     mem_en, 1'b0);
        chk("fl_rst_rdata",  rdata, 128'h0);
        chk("fl_rst_port",   {a_we, b_we, a_addr, b_addr}, 16'h0);
        tick();
        rst_i = 1'b0;
        req   = 4'b0000;
        #1;
        chk("fl_post_rvalid", rvalid, 4'b0000);
`ifdef BRAM_ARB_INIT_CLEAR_EN
        chk("fl_post_clr", {mem_en, a_addr, b_addr}, {1'b1, 7'd0, 7'd1});
        run_clear();
`else
        chk("fl_post_ready", ready, 1'b1);
`endif

        // rr_ptr restarts at 0: requester 0 takes port A ahead of 3.
        req = 4'b1001;
        #1;
        chk("pr_gnt",  gnt, 4'b1001);
        chk("pr_addr", {a_addr, b_addr}, {7'd20, 7'd23});
        tick();
        req = 4'b0000;
        chk("pr_rvalid", rvalid, 4'b1001);
`ifdef BRAM_ARB_INIT_CLEAR_EN
        chk("pr_rdata", {rd[3], rd[0]}, 64'h0);
`else
        chk("pr_rdata", {rd[3], rd[0]}, {32'h4444_4444, 32'h1111_1111});
`endif
        tick();
        chk("pr_idle_rvalid", rvalid, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_dp_arbiter.md
# bram_dp_arbiter

Round-robin arbiter and initialization sequencer that shares one dual-port block RAM (two independent read/write ports, common enable, registered read data, write-first on each port) among `N_REQ` requesters, e.g. the cores of the multiprocessor sharing a lookup table. Each cycle it grants up to two requests, one per RAM port, and routes the registered read data back to the requester that issued each read. After reset it can optionally zero the whole RAM before accepting traffic.

## Interface
- `N_REQ`, 4: number of requesters, at least 2.
- `DATA_WIDTH`, 32: RAM word width.
- `N_ENTRIES`, 128: RAM depth, power of two, at least 2; `AW = $clog2(N_ENTRIES)`.
- `clk_i` in 1: clock, all logic on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in N_REQ: request per requester, held until granted.
- `we_i` in N_REQ: 1 = write, 0 = read, per requester.
- `addr_i` in N_REQ*AW: address; requester i occupies bits [i*AW +: AW].
- `wdata_i` in N_REQ*DATA_WIDTH: write data, same packing.
- `gnt_o` out N_REQ: combinational grant; the request is consumed on the clock edge where `gnt_o[i]`=1.
- `rvalid_o` out N_REQ: registered; read data for requester i is on its slice of `rdata_o`.
- `rdata_o` out N_REQ*DATA_WIDTH: read data per requester, valid only with `rvalid_o[i]`.
- `ready_o` out 1: registered; 1 once the arbiter accepts requests.
- `mem_en_o` out 1: RAM enable.
- `mem_a_we_o`, `mem_b_we_o` out 1: RAM port A and B write enables.
- `mem_a_addr_o`, `mem_b_addr_o` out AW: RAM port addresses.
- `mem_a_data_o`, `mem_b_data_o` out DATA_WIDTH: RAM write data.
- `mem_a_data_i`, `mem_b_data_i` in DATA_WIDTH: RAM read data, valid one cycle after the access.

## Operation
- FSM states: CLEAR and RUN. Reset enters CLEAR when the macro below is defined, otherwise RUN.
- CLEAR: a counter k runs 0..N_ENTRIES/2-1. Port A writes 0 to address 2k, port B writes 0 to address 2k+1, and `mem_en_o`=1. `gnt_o` stays 0 and `req_i` is ignored. After k=N_ENTRIES/2-1 the FSM enters RUN.
- RUN arbitration: scan requesters circularly starting at `rr_ptr`, which resets to 0.
  - First asserted request is winner W0 and goes to port A.
  - Next asserted request is winner W1 and goes to port B.
- Conflict rule: if `addr(W0)==addr(W1)` and either one writes, only W0 is granted that cycle. Two reads of the same address are both granted.
- Pointer update: after any grant, `rr_ptr` becomes (index of the last granted requester + 1) mod N_REQ. With no grant, `rr_ptr` is held.
- RAM drive: `mem_en_o`=|`gnt_o`. Each port's we/addr/data come from its winner. An unused port drives we=0, addr=0, data=0.
- Read return:
  - A registered record of {granted read, requester id, port} is kept per port.
  - Next cycle, `rvalid_o[id]`=1 and `rdata_o[id]` = that port's `mem_*_data_i`.
  - Writes produce no `rvalid_o`.
  - `rdata_o` slices hold their last value when not valid.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `mem_en_o`=0, all `mem_*_we_o`=0, addr/data outputs 0, `rr_ptr`=0, k=0.
- `ready_o` reset value: 0 with clear enabled, 1 without.
- Clear duration is N_ENTRIES/2 cycles. `ready_o` rises in the cycle after the final clear write; the first grant is possible in that same cycle.
- Grant to `rvalid_o`: exactly 1 cycle. Full throughput is 2 accesses per cycle, with no bubbles between grants.
- Asserting `rst_i` at any time, including mid-clear or with reads in flight:
  - Immediately drops `gnt_o`, `rvalid_o` and `mem_en_o`.
  - Discards pending read returns.
  - Restarts CLEAR from k=0, or RUN without clear.
- A requester granted a read may re-request in the cycle `rvalid_o` arrives. Its returns arrive in issue order.

## Configuration
- `BRAM_ARB_INIT_CLEAR_EN` defined: CLEAR state and counter are compiled in, the RAM is zeroed after every reset, and `ready_o` behaves as above.
- Macro undefined: no CLEAR logic is compiled; RAM contents are whatever they were before (initial contents after configuration), RUN is entered straight from reset, and `ready_o` is constant 1 out of reset.

## Test plan
- **Clear:** macro on, N_ENTRIES=128, release reset → 64 cycles of dual writes of 0 to addresses 0..127, `ready_o`=1 at cycle 65; then reads of addresses 5 and 127 return 0.
- **Dual grant:** all 4 requesters issue reads to distinct addresses at `rr_ptr`=0 → cycle 1 grants 0(A) and 1(B), cycle 2 grants 2(A) and 3(B); each `rvalid_o` arrives one cycle after its grant with the correct data.
- **Conflict:** requester 0 writes 0xA5A5A5A5 to address 10 while requester 1 reads address 10 → only 0 is granted; 1 is granted next cycle and reads 0xA5A5A5A5.
- **Same-address reads:** requesters 2 and 3 both read address 7, which holds 0x1234 → both are granted in one cycle and both `rvalid_o` show 0x1234.
- **Fairness:** requester 0 requests continuously and requester 3 requests once → requester 3 is granted within one cycle; no requester waits more than ceil(N_REQ/2) cycles.
- **Reset mid-operation:** assert `rst_i` during clear cycle 20 with the macro on, and once with reads in flight → outputs return to reset values immediately, no stale `rvalid_o`, and the clear restarts from address 0.
